// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the MOV/MOC port arbiter: access sizes, FSM states,
// and grant owner identifiers.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RELEASE,
    ST_FINISH,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check: is an access of the given size legal at
// the given low address bits.
module mem_align_check
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic       legal
);

  // Bytes go anywhere, halfwords on even addresses, words on multiples of 4.
  always_comb begin
    legal = 1'b0;
    case (size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = ~addr_lo[0];
      SZ_WORD: legal = (addr_lo == 2'b00);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single ram MOV/MOC port between instruction fetch (IF)
// and data memory (DM), sequences the four-phase handshake, checks
// alignment and times out a stuck MOC.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 16,
  parameter int DM_BURST_MAX = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [1:0]        dm_type,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_type,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_moc,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W   = $clog2(TIMEOUT + 1);
  localparam int BURST_W = $clog2(DM_BURST_MAX + 1);
  // The ISSUE cycle counts toward the wait window, so a stuck MOC gives
  // exactly TIMEOUT cycles of MOV; the release wait uses the same limit.
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 2);
  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(DM_BURST_MAX);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [BURST_W-1:0]  burst, burst_n;

  logic                dm_win, if_win, grant, legal;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [1:0]          sel_type;
  logic [DATA_W-1:0]   sel_wdata;

  mem_align_check u_align (
    .addr_lo (sel_addr[1:0]),
    .size    (sel_type),
    .legal   (legal)
  );

  // Request selection: DM wins unless IF is waiting and the DM burst is used up.
  always_comb begin
    dm_win    = dm_req && (!if_req || (burst < BURST_CAP));
    if_win    = !dm_win && if_req;
    grant     = (state == ST_IDLE) && (dm_win || if_win);
    sel_rw    = dm_win ? dm_rw    : 1'b1;
    sel_addr  = dm_win ? dm_addr  : if_addr;
    sel_type  = dm_win ? dm_type  : SZ_WORD;
    sel_wdata = dm_win ? dm_wdata : '0;
  end

  // Next-state, timeout counter and burst counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    burst_n = burst;
    case (state)
      ST_IDLE: begin
        if (dm_win && if_req)     burst_n = burst + BURST_W'(1);
        else if (if_win || !if_req) burst_n = '0;
        if (grant) state_n = legal ? ST_ISSUE : ST_ERROR;
      end
      ST_ISSUE: begin
        state_n = ST_WAIT_ACK;
        cnt_n   = '0;
      end
      ST_WAIT_ACK: begin
        if (mem_moc) begin
          state_n = ST_RELEASE;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n = ST_ERROR;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!mem_moc)            state_n = ST_FINISH;
        else if (cnt == TO_LAST) state_n = ST_ERROR;
        else                     cnt_n   = cnt + CNT_W'(1);
      end
      ST_FINISH: state_n = ST_IDLE;
      ST_ERROR:  state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= ST_IDLE;
      cnt   <= '0;
      burst <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      burst <= burst_n;
    end
  end

  // Grant latches: owner on every grant; port values only when an access
  // is actually issued, so they hold across misaligned rejects.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      owner     <= OWNER_IF;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_type  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (grant) owner <= dm_win ? OWNER_DM : OWNER_IF;
      if (grant && legal) begin
        mem_rw    <= sel_rw;
        mem_addr  <= sel_addr;
        mem_type  <= sel_type;
        mem_wdata <= sel_wdata;
      end
      if ((state == ST_WAIT_ACK) && mem_moc && mem_rw) rdata <= mem_rdata;
    end
  end

  assign mem_mov = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
  assign busy    = (state != ST_IDLE);
  assign if_done = (state == ST_FINISH) && (owner == OWNER_IF);
  assign dm_done = (state == ST_FINISH) && (owner == OWNER_DM);
  assign if_err  = (state == ST_ERROR)  && (owner == OWNER_IF);
  assign dm_err  = (state == ST_ERROR)  && (owner == OWNER_DM);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single ram256x8 MOV/MOC port between two requesters: instruction fetch (IF, read-only, feeds IR) and data memory (DM, load/store, feeds MDR).
- Sequences the four-phase MOV/MOC handshake and checks alignment per access size.
- Guards against a stuck MOC with a timeout.
- Prevents IF starvation under back-to-back DM traffic.
- Sits between controlUnit and ram256x8, replacing the direct MAR/MOV/RW wiring.

Parameters:
- ADDR_W, 32, address width (matches MAR output)
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles to wait for each MOC edge before error
- DM_BURST_MAX, 2, consecutive DM grants allowed while IF is pending

Ports:
- CLK  in  1  system clock, rising edge
- CLR  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_done/if_err
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse, fetch data valid on rdata
- if_err  out  1  one-cycle pulse, fetch failed (misaligned/timeout)
- dm_req  in  1  data request, level, held until dm_done/dm_err
- dm_rw  in  1  1=read, 0=write
- dm_addr  in  ADDR_W  data address
- dm_type  in  2  size: 00 byte, 01 halfword, 10 word, 11 reserved
- dm_wdata  in  DATA_W  store data
- dm_done  out  1  one-cycle pulse, access complete
- dm_err  out  1  one-cycle pulse, access failed
- rdata  out  DATA_W  captured read data, held until next capture
- mem_mov  out  1  memory operation valid (to ram MOV)
- mem_rw  out  1  to ram RW, 1=read
- mem_addr  out  ADDR_W  to ram address
- mem_type  out  2  to ram typeData
- mem_wdata  out  DATA_W  to ram data-in
- mem_rdata  in  DATA_W  from ram data-out
- mem_moc  in  1  memory operation complete
- busy  out  1  FSM not in IDLE
- owner  out  1  current grant: 0=IF, 1=DM

Behaviour:
- Reset (CLR=0, async): FSM=IDLE. All outputs 0: rdata, mem_*, done/err pulses, busy, owner. dm_burst counter=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT_ACK, RELEASE, FINISH, ERROR.
- Arbitration is evaluated in IDLE only.
  - DM wins if dm_req and (not if_req or dm_burst < DM_BURST_MAX). Otherwise IF wins if if_req.
  - DM grant while if_req=1: dm_burst += 1. IF grant or if_req=0: dm_burst = 0.
- Grant latches owner, address, rw, type and wdata into internal registers; later requester changes are ignored. IF grants force rw=1 and type=10.
- Alignment is checked in IDLE on the latched request:
  - word needs addr[1:0]=00; halfword needs addr[0]=0; type 11 is always illegal.
  - Failure goes to ERROR with no MOV assertion.
- ISSUE (1 cycle): mem_addr/rw/type/wdata driven from latches, mem_mov=1; go to WAIT_ACK.
- WAIT_ACK: mem_mov held 1. On mem_moc=1, capture mem_rdata into rdata (reads only) and go to RELEASE. If the counter reaches TIMEOUT, go to ERROR.
- RELEASE: mem_mov=0. On mem_moc=0, go to FINISH. If the counter reaches TIMEOUT, go to ERROR.
- The timeout counter clears on entering WAIT_ACK and on entering RELEASE.
- FINISH (1 cycle): pulse the owner's done, then IDLE.
- ERROR (1 cycle): pulse the owner's err, mem_mov=0, then IDLE. rdata is unchanged.
- Minimum aligned access with 1-cycle MOC: req seen in IDLE at cycle 0, MOV high cycles 1-2, done at cycle 4, IDLE at cycle 5.
- Requester must drop req on the edge where done/err is high. A req still high in IDLE is treated as a new access.
- Simultaneous if_req/dm_req with dm_burst=0: DM granted.
- mem_addr/type/wdata hold their values after MOV drops, until the next ISSUE.
- CLR mid-access: mem_mov drops immediately. No done/err is pulsed and the requester must re-request.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encodings, OWNER_IF/OWNER_DM constants.
- One sub-module, mem_align_check: combinational, (addr[1:0], type) -> legal.
- FSM, arbitration and counters stay in the top.

Test Plan:
- IF read, if_addr=0x04, ram returns 0xE3A01005, MOC after 1 cycle -> MOV high cycles 1-2, if_done at cycle 4, rdata=0xE3A01005, mem_type=10.
- DM word write, addr=0x10, wdata=0xDEADBEEF -> mem_rw=0, mem_wdata=0xDEADBEEF during MOV, dm_done pulse, rdata unchanged.
- if_req and dm_req held continuously, DM_BURST_MAX=2 -> grant order DM, DM, IF, DM, DM, IF. Each IF done within one DM access after its wait.
- dm_type=10, addr=0x06 -> dm_err at cycle 1, mem_mov never asserted. Same for halfword at addr=0x03 and type 11.
- mem_moc held 0 with TIMEOUT=16 -> MOV high 16 cycles, then err pulse, mem_mov=0, FSM IDLE. Repeat with MOC stuck high in RELEASE -> err.
- CLR pulsed low during WAIT_ACK -> mem_mov=0 asynchronously, busy=0, no done/err. A fresh request after release completes normally.
